bcd_seq_display: RTL and testbench

BCD_SEQ_DISPLAY -- requirements
Module: bcd_seq_display

---
 rtl/bcd_seq_display.sv | 154 +++++++++++++++
 tb/tb_bcd_seq_display.sv | 195 +++++++++++++++++++
 2 files changed

// File: rtl/bcd_seq_display.sv
`default_nettype none
// ============================================================================
// Module   : bcd_seq_display
// Brief    : Prescaled up/down BCD counter with a multiplexed 7-segment scan.
// Revision : 1.0 - initial release
// ============================================================================
module bcd_seq_display #(
  parameter int N_DIGITS       = 4,
  parameter int TICK_DIV       = 20000000,
  parameter int SCAN_DIV       = 50000,
  parameter bit SEG_ACTIVE_LOW = 1'b1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  en,
  input  logic                  up,
  input  logic                  load,
  input  logic [4*N_DIGITS-1:0] load_val,
  output logic [6:0]            seg,
  output logic [N_DIGITS-1:0]   dig_sel,
  output logic [4*N_DIGITS-1:0] count,
  output logic                  wrap
);

  localparam int c_PW = $clog2(TICK_DIV);
  localparam int c_SW = $clog2(SCAN_DIV);
  localparam int c_IW = (N_DIGITS > 1) ? $clog2(N_DIGITS) : 1;

  function automatic logic [6:0] seg_drive(input logic [3:0] d);
    logic [6:0] p;
    case (d)
      4'd0:    p = 7'b0111111;
      4'd1:    p = 7'b0000110;
      4'd2:    p = 7'b1011011;
      4'd3:    p = 7'b1001111;
      4'd4:    p = 7'b1100110;
      4'd5:    p = 7'b1101101;
      4'd6:    p = 7'b1111101;
      4'd7:    p = 7'b0000111;
      4'd8:    p = 7'b1111111;
      default: p = 7'b1101111;
    endcase
    return SEG_ACTIVE_LOW ? ~p : p;
  endfunction

  logic [c_PW-1:0]       r_presc;
  logic [c_SW-1:0]       r_scan;
  logic [c_IW-1:0]       r_idx;
  logic [4*N_DIGITS-1:0] r_count;
  logic [N_DIGITS-1:0]   r_dig;
  logic [6:0]            r_seg;
  logic                  r_wrap;

  logic                  w_tick_end;
  logic                  w_step;
  logic                  w_scan_end;
  logic                  w_carry;
  logic [3:0]            w_d;
  logic [4*N_DIGITS-1:0] w_load_clamped;
  logic [4*N_DIGITS-1:0] w_stepped;
  logic [4*N_DIGITS-1:0] w_count_nxt;
  logic [c_PW-1:0]       w_presc_nxt;
  logic [c_SW-1:0]       w_scan_nxt;
  logic [c_IW-1:0]       w_idx_nxt;
  logic [3:0]            w_digit;

  assign w_tick_end = (r_presc == c_PW'(TICK_DIV - 1));
  assign w_step     = en & ~load & w_tick_end;
  assign w_scan_end = (r_scan == c_SW'(SCAN_DIV - 1));

  generate
    for (genvar i = 0; i < N_DIGITS; i++) begin : g_clamp
      assign w_load_clamped[4*i +: 4] =
        (load_val[4*i +: 4] > 4'd9) ? 4'd9 : load_val[4*i +: 4];
    end
  endgenerate

  // Ripple carry/borrow from digit 0; a carry left over at the top is a rollover.
  always_comb begin
    w_stepped = r_count;
    w_carry   = 1'b1;
    w_d       = 4'd0;
    for (int i = 0; i < N_DIGITS; i++) begin
      w_d = r_count[4*i +: 4];
      if (w_carry) begin
        if (up) begin
          if (w_d == 4'd9) begin
            w_stepped[4*i +: 4] = 4'd0;
          end else begin
            w_stepped[4*i +: 4] = w_d + 4'd1;
            w_carry             = 1'b0;
          end
        end else begin
          if (w_d == 4'd0) begin
            w_stepped[4*i +: 4] = 4'd9;
          end else begin
            w_stepped[4*i +: 4] = w_d - 4'd1;
            w_carry             = 1'b0;
          end
        end
      end
    end
  end

  always_comb begin
    w_count_nxt = r_count;
    w_presc_nxt = r_presc;
    if (load) begin
      w_count_nxt = w_load_clamped;
      w_presc_nxt = '0;
    end else if (en) begin
      w_presc_nxt = w_tick_end ? '0 : r_presc + 1'b1;
      if (w_tick_end) w_count_nxt = w_stepped;
    end
  end

  always_comb begin
    w_scan_nxt = w_scan_end ? '0 : r_scan + 1'b1;
    w_idx_nxt  = r_idx;
    if (w_scan_end) begin
      w_idx_nxt = (r_idx == c_IW'(N_DIGITS - 1)) ? '0 : r_idx + 1'b1;
    end
  end

  // Decode from next-state values so seg and dig_sel always agree after an edge.
  assign w_digit = w_count_nxt[{w_idx_nxt, 2'b00} +: 4];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_presc <= '0;
      r_scan  <= '0;
      r_idx   <= '0;
      r_count <= '0;
      r_dig   <= N_DIGITS'(1);
      r_seg   <= seg_drive(4'd0);
      r_wrap  <= 1'b0;
    end else begin
      r_presc <= w_presc_nxt;
      r_scan  <= w_scan_nxt;
      r_idx   <= w_idx_nxt;
      r_count <= w_count_nxt;
      r_dig   <= N_DIGITS'(1) << w_idx_nxt;
      r_seg   <= seg_drive(w_digit);
      r_wrap  <= w_step & w_carry;
    end
  end

  assign seg     = r_seg;
  assign dig_sel = r_dig;
  assign count   = r_count;
  assign wrap    = r_wrap;

endmodule
`default_nettype wire

// File: tb/tb_bcd_seq_display.sv
`default_nettype none
// ============================================================================
// Module   : tb_bcd_seq_display
// Brief    : Self-checking bench for bcd_seq_display (2 digits, fast dividers).
// Revision : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
module tb_bcd_seq_display;

  localparam int ND = 2;
  localparam int TD = 4;
  localparam int SD = 3;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       en = 1'b0;
  logic       up = 1'b1;
  logic       load = 1'b0;
  logic [7:0] load_val = 8'h00;
  logic [6:0] seg;
  logic [1:0] dig_sel;
  logic [7:0] count;
  logic       wrap;

  int n_pass   = 0;
  int n_checks = 0;

  bcd_seq_display #(
    .N_DIGITS(ND), .TICK_DIV(TD), .SCAN_DIV(SD), .SEG_ACTIVE_LOW(1'b1)
  ) dut (
    .clk(clk), .rst_n(rst_n), .en(en), .up(up), .load(load),
    .load_val(load_val), .seg(seg), .dig_sel(dig_sel), .count(count), .wrap(wrap)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] lv;
    logic       dir;
    int         n;
    logic [7:0] exp_count;
    int         exp_wraps;
  } vec_t;

  typedef struct {
    logic [7:0] cnt;
    int         wraps;
  } exp_t;

  vec_t vecs[8];
  exp_t sb[$];

  function automatic logic [6:0] seg_lo(input logic [3:0] d);
    logic [6:0] p;
    case (d)
      4'd0: p = 7'b0111111;  4'd1: p = 7'b0000110;
      4'd2: p = 7'b1011011;  4'd3: p = 7'b1001111;
      4'd4: p = 7'b1100110;  4'd5: p = 7'b1101101;
      4'd6: p = 7'b1111101;  4'd7: p = 7'b0000111;
      4'd8: p = 7'b1111111;  default: p = 7'b1101111;
    endcase
    return ~p;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

  initial begin
    int wraps;
    int cval;
    int idx;
    int saw7;
    int saw2;
    logic [7:0] exp_cnt;
    exp_t e;

    vecs[0] = '{8'h98, 1'b1,  8, 8'h00, 1};
    vecs[1] = '{8'h00, 1'b0,  4, 8'h99, 1};
    vecs[2] = '{8'h45, 1'b1, 12, 8'h48, 0};
    vecs[3] = '{8'h50, 1'b0,  4, 8'h49, 0};
    vecs[4] = '{8'h09, 1'b1,  4, 8'h10, 0};
    vecs[5] = '{8'hAF, 1'b1,  0, 8'h99, 0};
    vecs[6] = '{8'hF3, 1'b0,  8, 8'h91, 0};
    vecs[7] = '{8'h19, 1'b1,  4, 8'h20, 0};

    // Reset state
    #12;
    chk("rst_count", count, 8'h00);
    chk("rst_dig_sel", dig_sel, 2'b01);
    chk("rst_seg", seg, 7'b1000000);
    chk("rst_wrap", wrap, 1'b0);

    // Free run from reset: 40 clocks reaches 10
    en = 1'b1; up = 1'b1;
    @(negedge clk);
    rst_n = 1'b1;
    for (int k = 1; k <= 40; k++) begin
      tick();
      cval    = k / 4;
      exp_cnt = {4'(cval / 10), 4'(cval % 10)};
      idx     = (k / 3) % 2;
      chk("run_dig_sel", dig_sel, (idx == 1) ? 2'b10 : 2'b01);
      chk("run_seg", seg, seg_lo((idx == 1) ? exp_cnt[7:4] : exp_cnt[3:0]));
      chk("run_wrap", wrap, 1'b0);
    end
    chk("run_count", count, 8'h10);

    // Table: load, then count in a given direction
    for (int v = 0; v < 8; v++) begin
      load = 1'b1; load_val = vecs[v].lv; en = 1'b1;
      sb.push_back('{vecs[v].exp_count, vecs[v].exp_wraps});
      tick();
      wraps = (wrap === 1'b1) ? 1 : 0;
      load = 1'b0; up = vecs[v].dir;
      for (int c = 0; c < vecs[v].n; c++) begin
        tick();
        if (wrap === 1'b1) wraps++;
      end
      e = sb.pop_front();
      chk($sformatf("vec%0d_count", v), count, e.cnt);
      chk($sformatf("vec%0d_wraps", v), wraps, e.wraps);
    end

    // Load coincident with a step cycle
    load = 1'b1; load_val = 8'h20; up = 1'b1; tick();
    load = 1'b0; en = 1'b1;
    repeat (3) tick();
    chk("pre_coinc_count", count, 8'h20);
    load = 1'b1; load_val = 8'h3C; tick();
    chk("coinc_count", count, 8'h39);
    chk("coinc_wrap", wrap, 1'b0);
    load = 1'b0;
    repeat (3) tick();
    chk("coinc_restart_hold", count, 8'h39);
    tick();
    chk("coinc_restart_step", count, 8'h40);

    // Freeze with en=0; prescaler keeps its phase
    load = 1'b1; load_val = 8'h27; tick();
    load = 1'b0; en = 1'b1;
    repeat (2) tick();
    en = 1'b0; saw7 = 0; saw2 = 0;
    for (int c = 0; c < 20; c++) begin
      tick();
      chk("frz_count", count, 8'h27);
      if (dig_sel == 2'b01) begin
        chk("frz_seg_d0", seg, 7'b1111000);
        saw7 = 1;
      end else begin
        chk("frz_seg_d1", seg, 7'b0100100);
        saw2 = 1;
      end
    end
    chk("frz_both_digits", saw7 + saw2, 2);
    en = 1'b1; tick();
    chk("frz_resume_hold", count, 8'h27);
    tick();
    chk("frz_resume_step", count, 8'h28);

    // Asynchronous reset between edges
    repeat (5) tick();
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_count", count, 8'h00);
    chk("arst_dig_sel", dig_sel, 2'b01);
    chk("arst_seg", seg, 7'b1000000);
    chk("arst_wrap", wrap, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (3) tick();
    chk("post_rst_hold", count, 8'h00);
    tick();
    chk("post_rst_step", count, 8'h01);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
